// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kb_pkg
//  Purpose  : Shared constants, decoder state enum and event type for the
//             keyboard event port.
//  Revision : 1.0  initial release
// ============================================================================
package kb_pkg;

   // Scan-code prefixes and keyboard housekeeping bytes
   localparam logic [7:0] KB_EXT = 8'hE0;
   localparam logic [7:0] KB_BRK = 8'hF0;
   localparam logic [7:0] KB_ACK = 8'hFA;
   localparam logic [7:0] KB_BAT = 8'hAA;

   // Default processor port IDs
   localparam logic [7:0] KB_PORT_STATUS = 8'h10;
   localparam logic [7:0] KB_PORT_FLAGS  = 8'h11;
   localparam logic [7:0] KB_PORT_DATA   = 8'h12;

   // Queued event: extended flag, break flag, key code
   localparam int KB_EVT_W = 10;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } kb_event_t;

   // Prefix decoder states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kb_state_e;

   // ACK and BAT-complete bytes carry no key information outside a sequence
   function automatic logic kb_is_filler(input logic [7:0] code);
      return (code == KB_ACK) || (code == KB_BAT);
   endfunction

endpackage : kb_pkg
`default_nettype wire

// File: rtl/kb_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : kb_event_fifo
//  Purpose  : Synchronous FIFO with count. A push into a full FIFO succeeds
//             only when a pop frees a slot on the same edge; otherwise it is
//             dropped and the FIFO is left untouched.
//  Revision : 1.0  initial release
// ============================================================================
module kb_event_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 10,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             nonempty_nx_o
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;
   logic             do_pop, do_push;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer and count next-state; pointers wrap naturally
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
   end

   // Pointer and count registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o        = mem_q[rd_ptr_q];
   assign count_o       = count_q;
   assign nonempty_nx_o = (count_d != '0);

endmodule : kb_event_fifo
`default_nettype wire

// File: rtl/kb_event_port.sv
`default_nettype none
// ============================================================================
//  Module   : kb_event_port
//  Purpose  : Decodes PS/2 scan bytes (E0/F0 prefixes) into make/break
//             events, queues them, and exposes status/flags/data on the
//             PicoBlaze port bus with an interrupt while events are pending.
//  Revision : 1.0  initial release
// ============================================================================
module kb_event_port
   import kb_pkg::*;
#(
   parameter int         DEPTH       = 8,
   parameter logic [7:0] PORT_STATUS = KB_PORT_STATUS,
   parameter logic [7:0] PORT_FLAGS  = KB_PORT_FLAGS,
   parameter logic [7:0] PORT_DATA   = KB_PORT_DATA
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] Scan_Code,
   input  logic       Scan_Valid,
   input  logic [7:0] Port_ID,
   input  logic       Read_Strobe,
   output logic [7:0] In_Port,
   output logic       Interrupt
);

   localparam int AW = $clog2(DEPTH);

   kb_state_e             state_q, state_d;
   kb_event_t             evt_d;
   logic                  push_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            in_port_q, in_port_d;
   logic                  irq_q;

   logic [KB_EVT_W-1:0]   head_raw;
   kb_event_t             head;
   logic [AW:0]           count;
   logic                  full, empty, nonempty_nx;
   logic                  pop_req, status_rd, pop_ok;
   logic                  half;

   // Prefix decoder state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Prefix decoder next-state and event generation
   always_comb begin
      state_d = state_q;
      push_d  = 1'b0;
      evt_d   = '0;
      evt_d.code = Scan_Code;
      if (Scan_Valid) begin
         case (state_q)
            ST_IDLE: begin
               if (Scan_Code == KB_EXT)      state_d = ST_EXT;
               else if (Scan_Code == KB_BRK) state_d = ST_BRK;
               else if (!kb_is_filler(Scan_Code)) push_d = 1'b1;
            end
            ST_EXT: begin
               if (Scan_Code == KB_BRK) state_d = ST_EXT_BRK;
               else if (Scan_Code != KB_EXT) begin
                  push_d    = 1'b1;
                  evt_d.ext = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (Scan_Code == KB_EXT) state_d = ST_EXT_BRK;
               else if (Scan_Code != KB_BRK) begin
                  push_d    = 1'b1;
                  evt_d.brk = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: begin
               if (Scan_Code != KB_EXT && Scan_Code != KB_BRK) begin
                  push_d    = 1'b1;
                  evt_d.ext = 1'b1;
                  evt_d.brk = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         endcase
      end
   end

   assign pop_req   = Read_Strobe && (Port_ID == PORT_DATA);
   assign status_rd = Read_Strobe && (Port_ID == PORT_STATUS);
   assign pop_ok    = pop_req && !empty;

   kb_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KB_EVT_W)
   ) u_fifo (
      .clk_i         (CLK),
      .rst_i         (RESET),
      .push_i        (push_d),
      .pop_i         (pop_req),
      .din_i         (evt_d),
      .dout_o        (head_raw),
      .count_o       (count),
      .full_o        (full),
      .empty_o       (empty),
      .nonempty_nx_o (nonempty_nx)
   );

   assign head = head_raw;
   assign half = (count >= (AW+1)'(DEPTH / 2));

   // Sticky overflow: a status read clears it, a same-cycle overflow wins
   always_comb begin
      ovf_d = ovf_q;
      if (status_rd) ovf_d = 1'b0;
      if (push_d && full && !pop_ok) ovf_d = 1'b1;
   end

   // Port read mux; empty FIFO and unmapped IDs read as zero
   always_comb begin
      in_port_d = 8'h00;
      if (Port_ID == PORT_STATUS)
         in_port_d = {ovf_q, 4'b0000, full, half, !empty};
      else if (Port_ID == PORT_FLAGS && !empty)
         in_port_d = {6'b000000, head.ext, head.brk};
      else if (Port_ID == PORT_DATA && !empty)
         in_port_d = head.code;
   end

   // Output registers: read data, overflow flag, interrupt
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ovf_q     <= 1'b0;
         in_port_q <= 8'h00;
         irq_q     <= 1'b0;
      end else begin
         ovf_q     <= ovf_d;
         in_port_q <= in_port_d;
         irq_q     <= nonempty_nx;
      end
   end

   assign In_Port   = in_port_q;
   assign Interrupt = irq_q;

endmodule : kb_event_port
`default_nettype wire

// File: tb/tb_kb_event_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kb_event_port
//  Purpose  : Self-checking bench for kb_event_port against a queue-based
//             reference of the keyboard event rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kb_event_port;

   localparam int         DEPTH = 8;
   localparam logic [7:0] P_ST  = 8'h10;
   localparam logic [7:0] P_FL  = 8'h11;
   localparam logic [7:0] P_DA  = 8'h12;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] Scan_Code = 8'h00;
   logic       Scan_Valid = 1'b0;
   logic [7:0] Port_ID = 8'h00;
   logic       Read_Strobe = 1'b0;
   logic [7:0] In_Port;
   logic       Interrupt;

   int total = 0;
   int bad   = 0;

   // Reference state: pending queue, sticky overflow, pending prefix flags
   logic [9:0] q[$];
   logic       m_ovf = 1'b0;
   logic       p_ext = 1'b0;
   logic       p_brk = 1'b0;

   always #5 CLK = ~CLK;

   kb_event_port #(
      .DEPTH       (DEPTH),
      .PORT_STATUS (P_ST),
      .PORT_FLAGS  (P_FL),
      .PORT_DATA   (P_DA)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .Scan_Code   (Scan_Code),
      .Scan_Valid  (Scan_Valid),
      .Port_ID     (Port_ID),
      .Read_Strobe (Read_Strobe),
      .In_Port     (In_Port),
      .Interrupt   (Interrupt)
   );

   function automatic logic [7:0] m_read(input logic [7:0] port);
      int n;
      n = q.size();
      if (port == P_ST)
         return {m_ovf, 4'b0000, n == DEPTH, n >= DEPTH / 2, n != 0};
      if (port == P_FL && n != 0) return {6'b000000, q[0][9:8]};
      if (port == P_DA && n != 0) return q[0][7:0];
      return 8'h00;
   endfunction

   // One clock of stimulus, reference update and output comparison
   task automatic cycle(input logic sv, input logic [7:0] code,
                        input logic rs, input logic [7:0] port);
      logic [7:0] exp_in;
      logic [9:0] ev;
      logic       have_ev;
      @(negedge CLK);
      Scan_Valid  = sv;
      Scan_Code   = code;
      Read_Strobe = rs;
      Port_ID     = port;
      exp_in      = m_read(port);
      @(posedge CLK);
      #1;
      have_ev = 1'b0;
      ev      = '0;
      if (sv) begin
         if (code == 8'hE0) p_ext = 1'b1;
         else if (code == 8'hF0) p_brk = 1'b1;
         else if (p_ext || p_brk || (code != 8'hFA && code != 8'hAA)) begin
            ev      = {p_ext, p_brk, code};
            have_ev = 1'b1;
            p_ext   = 1'b0;
            p_brk   = 1'b0;
         end
      end
      if (rs && port == P_DA && q.size() != 0) void'(q.pop_front());
      if (rs && port == P_ST) m_ovf = 1'b0;
      if (have_ev) begin
         if (q.size() < DEPTH) q.push_back(ev);
         else m_ovf = 1'b1;
      end
      total++;
      assert (In_Port === exp_in) else begin
         bad++;
         $error("FAIL in_port port=%h got=%h exp=%h", port, In_Port, exp_in);
      end
      total++;
      assert (Interrupt === (q.size() != 0)) else begin
         bad++;
         $error("FAIL interrupt got=%b exp=%b", Interrupt, q.size() != 0);
      end
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic send(input logic [7:0] code);
      cycle(1'b1, code, 1'b0, 8'h00);
   endtask

   // PicoBlaze-style read: address cycle, then strobe cycle
   task automatic rd(input logic [7:0] port);
      cycle(1'b0, 8'h00, 1'b0, port);
      cycle(1'b0, 8'h00, 1'b1, port);
   endtask

   task automatic chk_in(input string tag, input logic [7:0] exp);
      total++;
      assert (In_Port === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, In_Port, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Scan_Valid  = 1'b0;
      Read_Strobe = 1'b0;
      #2;
      RESET = 1'b1;
      #1;
      total++;
      assert (In_Port === 8'h00 && Interrupt === 1'b0) else begin
         bad++;
         $error("FAIL reset in_port=%h irq=%b exp=00/0", In_Port, Interrupt);
      end
      q.delete();
      m_ovf = 1'b0;
      p_ext = 1'b0;
      p_brk = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] pt;
      int         r;

      do_reset();
      idle();
      chk_in("reset_idle", 8'h00);

      // Plain make
      send(8'h1C);
      rd(P_FL);  chk_in("make_flags", 8'h00);
      rd(P_DA);  chk_in("make_data", 8'h1C);
      rd(P_ST);  chk_in("make_status_after", 8'h00);

      // Extended break and plain break
      send(8'hE0); send(8'hF0); send(8'h75);
      rd(P_FL);  chk_in("extbrk_flags", 8'h03);
      rd(P_DA);  chk_in("extbrk_data", 8'h75);
      send(8'hF0); send(8'h1C);
      rd(P_FL);  chk_in("brk_flags", 8'h01);
      rd(P_DA);  chk_in("brk_data", 8'h1C);

      // Filler bytes in idle, repeated prefixes
      send(8'hFA); send(8'hAA);
      rd(P_ST);  chk_in("filler_status", 8'h00);
      send(8'hE0); send(8'hE0); send(8'hFA);
      rd(P_FL);  chk_in("ext_fa_flags", 8'h02);
      rd(P_DA);  chk_in("ext_fa_data", 8'hFA);
      send(8'hF0); send(8'hE0); send(8'hF0); send(8'h11);
      rd(P_FL);  chk_in("brk_e0_flags", 8'h03);
      rd(P_DA);  chk_in("brk_e0_data", 8'h11);

      // Reset mid-prefix
      send(8'hE0);
      do_reset();
      send(8'h1C);
      rd(P_FL);  chk_in("rst_prefix_flags", 8'h00);
      rd(P_DA);  chk_in("rst_prefix_data", 8'h1C);

      // Overflow: nine codes into eight slots
      for (int i = 1; i <= 9; i++) send(8'(i));
      cycle(1'b0, 8'h00, 1'b0, P_ST); chk_in("ovf_status", 8'h87);
      rd(8'h33); chk_in("unmapped", 8'h00);
      for (int i = 1; i <= 8; i++) begin
         rd(P_DA); chk_in("ovf_pop", 8'(i));
      end
      rd(P_ST);  chk_in("ovf_clear_read", 8'h80);
      rd(P_ST);  chk_in("ovf_cleared", 8'h00);

      // Full FIFO: push and pop on the same edge
      for (int i = 1; i <= 8; i++) send(8'(i));
      cycle(1'b0, 8'h00, 1'b0, P_DA);
      cycle(1'b1, 8'h0A, 1'b1, P_DA); chk_in("full_pp_data", 8'h01);
      cycle(1'b0, 8'h00, 1'b0, P_ST); chk_in("full_pp_status", 8'h07);
      for (int i = 2; i <= 8; i++) begin
         rd(P_DA); chk_in("full_pp_pop", 8'(i));
      end
      rd(P_DA);  chk_in("full_pp_last", 8'h0A);

      // Pop from empty
      rd(P_DA);  chk_in("empty_pop", 8'h00);
      send(8'h2B);
      rd(P_DA);  chk_in("after_empty_pop", 8'h2B);
      rd(P_ST);  chk_in("after_empty_status", 8'h00);

      // Randomized traffic against the reference
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 7);
         case (r)
            0:       b = 8'hE0;
            1:       b = 8'hF0;
            2:       b = 8'hFA;
            3:       b = 8'hAA;
            default: b = 8'($urandom_range(0, 255));
         endcase
         r = $urandom_range(0, 9);
         if (r < 5)       pt = P_DA;
         else if (r < 7)  pt = P_FL;
         else if (r < 9)  pt = P_ST;
         else             pt = 8'($urandom_range(0, 255));
         cycle($urandom_range(0, 2) == 0, b, $urandom_range(0, 1) == 1, pt);
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_kb_event_port
`default_nettype wire
